// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: two-requester valid/ready arbiter in front of a bank of
// NREG external W-bit registers. One transaction is in flight at a time:
// IDLE -> WRITE (one load strobe) or READ (one registered rdata/rvalid pulse).
// Optional feature macro: REG_ARB_ROUND_ROBIN_EN (round-robin on contention);
// when undefined, requester 0 has fixed priority.
module reg_bank_arbiter #(
    parameter int NREG = 8,
    parameter int W    = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [AW-1:0]     req0_addr,
    input  logic [W-1:0]      req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [AW-1:0]     req1_addr,
    input  logic [W-1:0]      req1_wdata,
    output logic [NREG-1:0]   reg_load,
    output logic [W-1:0]      reg_in,
    input  logic [NREG*W-1:0] reg_out,
    output logic [W-1:0]      rdata,
    output logic              rvalid,
    output logic              rid,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [W-1:0]  wdata_q, wdata_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          rid_q, rid_d;

    logic          grant1;
    logic          idle;
    logic [W-1:0]  rd_sel;

    assign idle = (state_q == S_IDLE);

    // Pick the winner from the current valids; 1 means requester 1 wins
    always_comb begin
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
            grant1 = ~last_q;
`else
            // last_q is tracked in both builds; fixed priority ignores it
            grant1 = last_q & 1'b0;
`endif
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = idle & req0_valid & ~grant1;
    assign req1_ready = idle & req1_valid & grant1;

    // Read mux; addresses past the bank return zero
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == AW'(i)) rd_sel = reg_out[i*W +: W];
        end
    end

    // One-hot load strobe, only during the WRITE cycle and only for in-range addresses
    always_comb begin
        reg_load = '0;
        if (state_q == S_WRITE) begin
            for (int i = 0; i < NREG; i++) begin
                reg_load[i] = (addr_q == AW'(i));
            end
        end
    end

    // Transaction FSM: latch on accept, spend exactly one cycle in WRITE or READ
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        id_d     = id_q;
        last_d   = last_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    addr_d  = req1_ready ? req1_addr  : req0_addr;
                    wdata_d = req1_ready ? req1_wdata : req0_wdata;
                    state_d = (req1_ready ? req1_we : req0_we) ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                rdata_d  = rd_sel;
                rvalid_d = 1'b1;
                rid_d    = id_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            id_q     <= id_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
        end
    end

    assign reg_in = wdata_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign busy   = ~idle;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter (NREG=6 so out-of-range addresses exist).
// A behavioural register bank hangs off reg_load/reg_in/reg_out; accepts are
// observed at the clock edge and expected reads are queued from a shadow copy.
module tb_reg_bank_arbiter;
    localparam int NREG = 6;
    localparam int W    = 16;
    localparam int AW   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_we;
    logic [AW-1:0]     req0_addr;
    logic [W-1:0]      req0_wdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [AW-1:0]     req1_addr;
    logic [W-1:0]      req1_wdata;
    logic [NREG-1:0]   reg_load;
    logic [W-1:0]      reg_in;
    logic [NREG*W-1:0] reg_out;
    logic [W-1:0]      rdata;
    logic              rvalid, rid, busy;

    typedef struct { logic id; logic [W-1:0] data; int edge_n; } exp_t;
    exp_t        exp_q[$];
    int          grant_q[$];
    int          acc_edge_q[$];
    int          acc_cnt[2];
    int          edge_cnt;
    logic [W-1:0] bank[NREG];
    logic [W-1:0] shadow[NREG];
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.NREG(NREG), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .reg_load(reg_load), .reg_in(reg_in), .reg_out(reg_out),
        .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy)
    );

    // external register bank (not reset by the arbiter)
    always @(posedge clk)
        for (int i = 0; i < NREG; i++) if (reg_load[i]) bank[i] <= reg_in;

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NREG; i++) reg_out[i*W +: W] = bank[i];
    end

    task automatic note_accept(input int id, input logic we, input logic [AW-1:0] a,
                               input logic [W-1:0] d);
        exp_t e;
        grant_q.push_back(id);
        acc_edge_q.push_back(edge_cnt);
        acc_cnt[id]++;
        if (we) begin
            if (a < NREG) shadow[a] = d;
        end else begin
            e.id     = (id != 0);
            e.data   = (a < NREG) ? shadow[a] : '0;
            e.edge_n = edge_cnt;
            exp_q.push_back(e);
        end
    endtask

    // accept monitor: samples pre-edge handshake values
    always @(posedge clk) begin
        if (!rst) begin
            n_checks++;
            if (req0_ready && req1_ready) begin
                n_fail++;
                $display("FAIL dual_ready: both readies high at edge %0d", edge_cnt);
            end
            if (req0_valid && req0_ready) note_accept(0, req0_we, req0_addr, req0_wdata);
            if (req1_valid && req1_ready) note_accept(1, req1_we, req1_addr, req1_wdata);
        end
        edge_cnt++;
    end

    // read-response scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: rdata=%h rid=%0d, no read pending", rdata, rid);
            end else begin
                e = exp_q.pop_front();
                if (rdata !== e.data || rid !== e.id || edge_cnt != e.edge_n + 2) begin
                    n_fail++;
                    $display("FAIL read_resp: got rdata=%h rid=%0d edge=%0d, want rdata=%h rid=%0d edge=%0d",
                             rdata, rid, edge_cnt, e.data, e.id, e.edge_n + 2);
                end
            end
        end
    end

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // called at a negedge; returns at the negedge inside the WRITE/READ cycle
    task automatic issue(input int id, input logic we, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
        int start;
        bit ok;
        start = acc_cnt[id];
        ok = 0;
        drive(id, 1'b1, we, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_cnt[id] != start) begin ok = 1; break; end
        end
        drive(id, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_timeout: requester %0d not accepted within 20 cycles", id);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (reg_load !== '0 || reg_in !== '0 || rdata !== '0 || rvalid !== 1'b0 ||
            rid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: load=%b in=%h rdata=%h rvalid=%b rid=%b busy=%b rdy=%b%b, want all 0",
                     reg_load, reg_in, rdata, rvalid, rid, busy, req0_ready, req1_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        issue(0, 1'b1, 3'd3, 16'hBEEF);
        n_checks++;
        if (reg_load !== 6'b001000 || reg_in !== 16'hBEEF || busy !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_strobe: load=%b in=%h busy=%b rdy0=%b, want 001000 beef 1 0",
                     reg_load, reg_in, busy, req0_ready);
        end
        @(negedge clk);
        n_checks++;
        if (reg_load !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_one_cycle: load=%b busy=%b, want 0 0", reg_load, busy);
        end
        issue(0, 1'b0, 3'd3, 16'h0);
        n_checks++;
        if (rvalid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_cycle: rvalid=%b busy=%b, want 0 1", rvalid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 16'hBEEF || rid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data: rvalid=%b rdata=%h rid=%b, want 1 beef 0", rvalid, rdata, rid);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_pulse: rvalid=%b one cycle later, want 0", rvalid);
        end
    endtask

    task automatic test_contention();
        int base;
        int want[4];
        issue(0, 1'b1, 3'd1, 16'h1111);
        @(negedge clk);
        issue(1, 1'b1, 3'd2, 16'h2222);
        do_reset();
`ifdef REG_ARB_ROUND_ROBIN_EN
        want = '{0, 1, 0, 1};
`else
        want = '{0, 0, 0, 0};
`endif
        base = grant_q.size();
        drive(0, 1'b1, 1'b0, 3'd1, '0);
        drive(1, 1'b1, 1'b0, 3'd2, '0);
        for (int k = 0; k < 40 && grant_q.size() < base + 4; k++) @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (grant_q.size() < base + 4) begin
            n_fail++;
            $display("FAIL contention_count: %0d grants, want 4", grant_q.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (grant_q[base+k] != want[k]) begin
                    n_fail++;
                    $display("FAIL contention_order[%0d]: got %0d, want %0d", k, grant_q[base+k], want[k]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (acc_edge_q[base+k] - acc_edge_q[base+k-1] != 2) begin
                        n_fail++;
                        $display("FAIL contention_spacing[%0d]: got %0d cycles, want 2",
                                 k, acc_edge_q[base+k] - acc_edge_q[base+k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        issue(1, 1'b1, 3'd5, 16'h5555);
        n_checks++;
        if (reg_load !== 6'b100000) begin
            n_fail++;
            $display("FAIL top_addr_strobe: load=%b, want 100000", reg_load);
        end
        @(negedge clk);
        issue(1, 1'b0, 3'd5, 16'h0);
        @(negedge clk);
        issue(0, 1'b1, 3'd7, 16'hAAAA);
        n_checks++;
        if (reg_load !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write: load=%b busy=%b, want 0 1", reg_load, busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write_len: busy=%b, want 0", busy);
        end
        issue(1, 1'b0, 3'd6, 16'h0);
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0000 || rid !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read: rvalid=%b rdata=%h rid=%b, want 1 0000 1", rvalid, rdata, rid);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int s0, s1;
        logic [W-1:0] first_rd;
        @(negedge clk);
        issue(1, 1'b1, 3'd0, 16'h0F0F);
        do_reset();
        base = grant_q.size();
        s0 = acc_cnt[0];
        s1 = acc_cnt[1];
        first_rd = 'x;
        drive(0, 1'b1, 1'b0, 3'd0, '0);
        drive(1, 1'b1, 1'b1, 3'd0, 16'h1234);
        for (int k = 0; k < 20 && (req0_valid || req1_valid); k++) begin
            @(negedge clk);
            if (rvalid) first_rd = rdata;
            if (acc_cnt[0] != s0) req0_valid = 1'b0;
            if (acc_cnt[1] != s1) req1_valid = 1'b0;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (grant_q.size() != base + 2 || grant_q[base] != 0 || grant_q[base+1] != 1) begin
            n_fail++;
            $display("FAIL hazard_order: %0d grants, want order 0 then 1", grant_q.size() - base);
        end
        n_checks++;
        if (first_rd !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL hazard_old: first read %h, want 0f0f", first_rd);
        end
        @(negedge clk);
        issue(0, 1'b0, 3'd0, 16'h0);
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL hazard_new: rvalid=%b rdata=%h, want 1 1234", rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid_op();
        int base;
        @(negedge clk);
        issue(0, 1'b0, 3'd3, 16'h0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_checks++;
        if (busy !== 1'b0 || rvalid !== 1'b0 || reg_load !== '0 || rdata !== '0 ||
            rid !== 1'b0 || reg_in !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b rvalid=%b load=%b rdata=%h rid=%b in=%h, want all 0",
                     busy, rvalid, reg_load, rdata, rid, reg_in);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_rvalid: rvalid=%b, want 0", rvalid);
        end
        rst = 1'b0;
        base = grant_q.size();
        drive(0, 1'b1, 1'b0, 3'd1, '0);
        drive(1, 1'b1, 1'b0, 3'd2, '0);
        for (int k = 0; k < 20 && grant_q.size() == base; k++) @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (grant_q.size() != base + 1 || grant_q[base] != 0) begin
            n_fail++;
            $display("FAIL post_reset_grant: %0d grants, first=%0d, want one grant to 0",
                     grant_q.size() - base, (grant_q.size() > base) ? grant_q[base] : -1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || reg_load !== '0 ||
                rvalid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle[%0d]: rdy=%b%b load=%b rvalid=%b busy=%b, want all 0",
                         k, req0_ready, req1_ready, reg_load, rvalid, busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_cnt = 0;
        acc_cnt  = '{0, 0};
        for (int i = 0; i < NREG; i++) begin
            bank[i]   = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        test_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads never answered, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
